// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types and constants for the fetch redirect controller.
//   frc_state_e : sequencer states (request, wait for response, hold for IDU, drain stale rsp)
//   FrcResetPc  : default PC of the first fetch after reset
package fetch_redirect_ctrl_pkg;

  localparam int unsigned FrcStW     = 2;
  localparam logic [31:0] FrcResetPc = 32'h8000_0000;

  typedef enum logic [FrcStW-1:0] {
    StReq   = 2'd0,
    StWait  = 2'd1,
    StHold  = 2'd2,
    StDrain = 2'd3
  } frc_state_e;

endpackage

// File: rtl/fetch_redirect_ctrl_redirect_arb.sv
// Redirect arbitration for the fetch sequencer.
//   Combines IDU branch results and CSR trap/mret redirects into one event, trap winning a
//   same-cycle tie, and word-aligns the chosen target. Also keeps the pending redirect that
//   arrives while a fetch request is still waiting for acceptance.
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   br_valid_i/br_taken_i        branch resolved / taken
//   br_target_i, trap_valid_i, trap_target_i   redirect sources
//   pend_set_i / pend_clr_i      record / drop a pending redirect (set has priority)
//   redirect_o, target_o         redirect event this cycle and its aligned target
//   pend_o, pend_pc_o            pending redirect flag and its target
module fetch_redirect_ctrl_redirect_arb #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              br_valid_i,
  input  logic              br_taken_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic              trap_valid_i,
  input  logic [ADDR_W-1:0] trap_target_i,
  input  logic              pend_set_i,
  input  logic              pend_clr_i,
  output logic              redirect_o,
  output logic [ADDR_W-1:0] target_o,
  output logic              pend_o,
  output logic [ADDR_W-1:0] pend_pc_o
);

  logic [ADDR_W-1:0] sel;
  logic              pend_d, pend_q;
  logic [ADDR_W-1:0] pend_pc_d, pend_pc_q;

  assign redirect_o = trap_valid_i | (br_valid_i & br_taken_i);
  assign sel        = trap_valid_i ? trap_target_i : br_target_i;
  assign target_o   = sel & ~ADDR_W'(3);

  always_comb begin
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    if (pend_set_i) begin
      // A later redirect simply overwrites the earlier pending target.
      pend_d    = 1'b1;
      pend_pc_d = target_o;
    end else if (pend_clr_i) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  assign pend_o    = pend_q;
  assign pend_pc_o = pend_pc_q;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Next-PC sequencer between the IFU fetch port and the IDU.
//   Issues one fetch at a time, holds the returned instruction until the IDU takes it, and
//   applies branch / trap redirects, discarding any wrong-path response still in flight.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   fetch_valid_o/ready_i/addr_o  fetch request handshake
//   rsp_valid_i, rsp_inst_i       fetch response (single-cycle pulse, always accepted)
//   inst_valid_o/ready_i, inst_o, inst_pc_o   instruction handoff to the IDU
//   br_valid_i/taken_i/target_i   branch unit result
//   trap_valid_i, trap_target_i   CSR trap/mret redirect
//   flush_o                       redirect taken this cycle
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FrcResetPc)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              fetch_valid_o,
  input  logic              fetch_ready_i,
  output logic [ADDR_W-1:0] fetch_addr_o,
  input  logic              rsp_valid_i,
  input  logic [ADDR_W-1:0] rsp_inst_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [ADDR_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  input  logic              br_valid_i,
  input  logic              br_taken_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic              trap_valid_i,
  input  logic [ADDR_W-1:0] trap_target_i,
  output logic              flush_o
);

  frc_state_e        st_d, st_q;
  logic [ADDR_W-1:0] pc_d, pc_q;
  logic [ADDR_W-1:0] inst_d, inst_q;
  logic [ADDR_W-1:0] inst_pc_d, inst_pc_q;
  logic              redirect, pend, pend_set, pend_clr;
  logic [ADDR_W-1:0] target, pend_pc;

  fetch_redirect_ctrl_redirect_arb #(
    .ADDR_W(ADDR_W)
  ) u_arb (
    .clk_i        (clk),
    .rst_i        (rst),
    .br_valid_i   (br_valid_i),
    .br_taken_i   (br_taken_i),
    .br_target_i  (br_target_i),
    .trap_valid_i (trap_valid_i),
    .trap_target_i(trap_target_i),
    .pend_set_i   (pend_set),
    .pend_clr_i   (pend_clr),
    .redirect_o   (redirect),
    .target_o     (target),
    .pend_o       (pend),
    .pend_pc_o    (pend_pc)
  );

  always_comb begin
    st_d      = st_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    pend_set  = 1'b0;
    pend_clr  = 1'b0;
    unique case (st_q)
      StReq: begin
        if (fetch_ready_i) begin
          if (redirect) begin
            // Accepted fetch is already wrong-path: drain its response.
            st_d     = StDrain;
            pc_d     = target;
            pend_clr = 1'b1;
          end else if (pend) begin
            st_d     = StDrain;
            pc_d     = pend_pc;
            pend_clr = 1'b1;
          end else begin
            st_d = StWait;
          end
        end else if (redirect) begin
          // Request must stay stable until accepted; remember where to go afterwards.
          pend_set = 1'b1;
        end
      end
      StWait: begin
        if (redirect) begin
          pc_d = target;
          st_d = rsp_valid_i ? StReq : StDrain;
        end else if (rsp_valid_i) begin
          st_d      = StHold;
          inst_d    = rsp_inst_i;
          inst_pc_d = pc_q;
        end
      end
      StHold: begin
        if (redirect) begin
          pc_d = target;
          st_d = StReq;
        end else if (inst_ready_i) begin
          pc_d = pc_q + ADDR_W'(4);
          st_d = StReq;
        end
      end
      StDrain: begin
        if (redirect) begin
          pc_d = target;
        end
        if (rsp_valid_i) begin
          st_d = StReq;
        end
      end
      default: st_d = StReq;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q      <= StReq;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      st_q      <= st_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  // Gated by rst so no request is presented while the fetch bus is itself in reset.
  assign fetch_valid_o = (st_q == StReq) & ~rst;
  assign fetch_addr_o  = pc_q;
  assign inst_valid_o  = (st_q == StHold);
  assign inst_o        = inst_q;
  assign inst_pc_o     = inst_pc_q;
  assign flush_o       = redirect & ~rst;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
module tb_fetch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_valid_o, fetch_ready_i;
  logic [31:0] fetch_addr_o;
  logic        rsp_valid_i;
  logic [31:0] rsp_inst_i;
  logic        inst_valid_o, inst_ready_i;
  logic [31:0] inst_o, inst_pc_o;
  logic        br_valid_i, br_taken_i;
  logic [31:0] br_target_i;
  logic        trap_valid_i;
  logic [31:0] trap_target_i;
  logic        flush_o;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_redirect_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_valid_o(fetch_valid_o),
    .fetch_ready_i(fetch_ready_i),
    .fetch_addr_o (fetch_addr_o),
    .rsp_valid_i  (rsp_valid_i),
    .rsp_inst_i   (rsp_inst_i),
    .inst_valid_o (inst_valid_o),
    .inst_ready_i (inst_ready_i),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .br_valid_i   (br_valid_i),
    .br_taken_i   (br_taken_i),
    .br_target_i  (br_target_i),
    .trap_valid_i (trap_valid_i),
    .trap_target_i(trap_target_i),
    .flush_o      (flush_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    fetch_ready_i = 1'b0;
    rsp_valid_i   = 1'b0;
    rsp_inst_i    = '0;
    inst_ready_i  = 1'b0;
    br_valid_i    = 1'b0;
    br_taken_i    = 1'b0;
    br_target_i   = '0;
    trap_valid_i  = 1'b0;
    trap_target_i = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
  endtask

  // From REQ: accept the fetch, return a response one cycle later, end up in HOLD.
  task automatic to_hold(input logic [31:0] inst);
    fetch_ready_i = 1'b1;
    cyc();
    fetch_ready_i = 1'b0;
    rsp_valid_i   = 1'b1;
    rsp_inst_i    = inst;
    cyc();
    rsp_valid_i   = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    cyc();
    n_checks++; if (fetch_valid_o !== 1'b0) begin n_fail++;
      $display("FAIL rst_fetch_valid: got %b want 0", fetch_valid_o); end
    n_checks++; if (fetch_addr_o !== 32'h8000_0000) begin n_fail++;
      $display("FAIL rst_fetch_addr: got %h want 80000000", fetch_addr_o); end
    n_checks++; if (inst_valid_o !== 1'b0) begin n_fail++;
      $display("FAIL rst_inst_valid: got %b want 0", inst_valid_o); end
    n_checks++; if (inst_o !== 32'h0 || inst_pc_o !== 32'h0) begin n_fail++;
      $display("FAIL rst_inst: got %h/%h want 0/0", inst_o, inst_pc_o); end
    n_checks++; if (flush_o !== 1'b0) begin n_fail++;
      $display("FAIL rst_flush: got %b want 0", flush_o); end
    rst = 1'b0;
    #1;
    n_checks++; if (fetch_valid_o !== 1'b1) begin n_fail++;
      $display("FAIL rst_release_valid: got %b want 1", fetch_valid_o); end
  endtask

  task automatic test_straight_line();
    logic [31:0] exp_addr;
    do_reset();
    inst_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_addr = 32'h8000_0000 + 32'(4 * i);
      n_checks++; if (fetch_valid_o !== 1'b1 || fetch_addr_o !== exp_addr) begin n_fail++;
        $display("FAIL sl_fetch[%0d]: got %b/%h want 1/%h", i, fetch_valid_o, fetch_addr_o,
                 exp_addr); end
      fetch_ready_i = 1'b1;
      cyc();
      fetch_ready_i = 1'b0;
      n_checks++; if (fetch_valid_o !== 1'b0) begin n_fail++;
        $display("FAIL sl_one_outstanding[%0d]: got %b want 0", i, fetch_valid_o); end
      cyc();
      rsp_valid_i = 1'b1;
      rsp_inst_i  = 32'h1000_0013 + 32'(i);
      cyc();
      rsp_valid_i = 1'b0;
      n_checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h1000_0013 + 32'(i) ||
                      inst_pc_o !== exp_addr) begin n_fail++;
        $display("FAIL sl_inst[%0d]: got %b/%h/%h want 1/%h/%h", i, inst_valid_o, inst_o,
                 inst_pc_o, 32'h1000_0013 + 32'(i), exp_addr); end
      cyc();
      n_checks++; if (inst_valid_o !== 1'b0) begin n_fail++;
        $display("FAIL sl_inst_consumed[%0d]: got %b want 0", i, inst_valid_o); end
    end
    n_checks++; if (fetch_addr_o !== 32'h8000_000C) begin n_fail++;
      $display("FAIL sl_next_addr: got %h want 8000000c", fetch_addr_o); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++; if (fetch_valid_o !== 1'b1 || fetch_addr_o !== 32'h8000_0000) begin n_fail++;
        $display("FAIL bp_stable[%0d]: got %b/%h want 1/80000000", i, fetch_valid_o,
                 fetch_addr_o); end
    end
  endtask

  task automatic test_branch_in_wait();
    do_reset();
    fetch_ready_i = 1'b1;
    cyc();
    fetch_ready_i = 1'b0;
    br_valid_i = 1'b1; br_taken_i = 1'b0; br_target_i = 32'h8000_0500;
    #1;
    n_checks++; if (flush_o !== 1'b0) begin n_fail++;
      $display("FAIL br_not_taken_flush: got %b want 0", flush_o); end
    br_taken_i = 1'b1; br_target_i = 32'h8000_0101;
    #1;
    n_checks++; if (flush_o !== 1'b1) begin n_fail++;
      $display("FAIL br_wait_flush: got %b want 1", flush_o); end
    cyc();
    clear_inputs();
    n_checks++; if (fetch_valid_o !== 1'b0) begin n_fail++;
      $display("FAIL br_wait_draining: got %b want 0", fetch_valid_o); end
    rsp_valid_i = 1'b1; rsp_inst_i = 32'hDEAD_BEEF;
    cyc();
    rsp_valid_i = 1'b0;
    n_checks++; if (inst_valid_o !== 1'b0) begin n_fail++;
      $display("FAIL br_wait_rsp_dropped: got %b want 0", inst_valid_o); end
    n_checks++; if (fetch_valid_o !== 1'b1 || fetch_addr_o !== 32'h8000_0100) begin n_fail++;
      $display("FAIL br_wait_next: got %b/%h want 1/80000100", fetch_valid_o,
               fetch_addr_o); end
    // Redirect in the same cycle as the response: straight back to REQ.
    fetch_ready_i = 1'b1;
    cyc();
    fetch_ready_i = 1'b0;
    rsp_valid_i = 1'b1; rsp_inst_i = 32'h1111_1111;
    trap_valid_i = 1'b1; trap_target_i = 32'h8000_0300;
    cyc();
    clear_inputs();
    n_checks++; if (inst_valid_o !== 1'b0 || fetch_valid_o !== 1'b1 ||
                    fetch_addr_o !== 32'h8000_0300) begin n_fail++;
      $display("FAIL wait_rsp_redirect: got %b/%b/%h want 0/1/80000300", inst_valid_o,
               fetch_valid_o, fetch_addr_o); end
  endtask

  task automatic test_br_trap_hold();
    do_reset();
    to_hold(32'h0000_0073);
    cyc();
    n_checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0000_0073) begin n_fail++;
      $display("FAIL hold_stall: got %b/%h want 1/00000073", inst_valid_o, inst_o); end
    br_valid_i = 1'b1; br_taken_i = 1'b1; br_target_i = 32'h8000_0200;
    trap_valid_i = 1'b1; trap_target_i = 32'h8000_1000;
    #1;
    n_checks++; if (flush_o !== 1'b1) begin n_fail++;
      $display("FAIL hold_flush: got %b want 1", flush_o); end
    cyc();
    clear_inputs();
    n_checks++; if (inst_valid_o !== 1'b0) begin n_fail++;
      $display("FAIL hold_killed: got %b want 0", inst_valid_o); end
    n_checks++; if (fetch_valid_o !== 1'b1 || fetch_addr_o !== 32'h8000_1000) begin n_fail++;
      $display("FAIL trap_wins: got %b/%h want 1/80001000", fetch_valid_o, fetch_addr_o); end
  endtask

  task automatic test_redirect_req_stalled();
    do_reset();
    br_valid_i = 1'b1; br_taken_i = 1'b1; br_target_i = 32'h8000_0040;
    cyc();
    clear_inputs();
    n_checks++; if (fetch_valid_o !== 1'b1 || fetch_addr_o !== 32'h8000_0000) begin n_fail++;
      $display("FAIL stall_addr_held: got %b/%h want 1/80000000", fetch_valid_o,
               fetch_addr_o); end
    fetch_ready_i = 1'b1;
    cyc();
    fetch_ready_i = 1'b0;
    n_checks++; if (fetch_valid_o !== 1'b0) begin n_fail++;
      $display("FAIL stall_drain: got %b want 0", fetch_valid_o); end
    rsp_valid_i = 1'b1; rsp_inst_i = 32'hBAD0_0001;
    cyc();
    rsp_valid_i = 1'b0;
    n_checks++; if (inst_valid_o !== 1'b0 || fetch_addr_o !== 32'h8000_0040) begin n_fail++;
      $display("FAIL stall_next: got %b/%h want 0/80000040", inst_valid_o, fetch_addr_o); end
    // Two redirects while stalled: the younger one is the one that sticks.
    br_valid_i = 1'b1; br_taken_i = 1'b1; br_target_i = 32'h8000_0044;
    cyc();
    clear_inputs();
    trap_valid_i = 1'b1; trap_target_i = 32'h8000_0080;
    cyc();
    clear_inputs();
    fetch_ready_i = 1'b1;
    cyc();
    fetch_ready_i = 1'b0;
    rsp_valid_i = 1'b1;
    cyc();
    rsp_valid_i = 1'b0;
    n_checks++; if (fetch_addr_o !== 32'h8000_0080) begin n_fail++;
      $display("FAIL stall_youngest: got %h want 80000080", fetch_addr_o); end
  endtask

  task automatic test_wrap();
    do_reset();
    to_hold(32'h0000_0001);
    trap_valid_i = 1'b1; trap_target_i = 32'hFFFF_FFFF;
    cyc();
    clear_inputs();
    n_checks++; if (fetch_addr_o !== 32'hFFFF_FFFC) begin n_fail++;
      $display("FAIL wrap_align: got %h want fffffffc", fetch_addr_o); end
    to_hold(32'h0000_0002);
    n_checks++; if (inst_pc_o !== 32'hFFFF_FFFC) begin n_fail++;
      $display("FAIL wrap_inst_pc: got %h want fffffffc", inst_pc_o); end
    inst_ready_i = 1'b1;
    cyc();
    inst_ready_i = 1'b0;
    n_checks++; if (fetch_addr_o !== 32'h0000_0000) begin n_fail++;
      $display("FAIL wrap_pc: got %h want 00000000", fetch_addr_o); end
  endtask

  task automatic test_rst_in_hold();
    do_reset();
    to_hold(32'h0000_0013);
    n_checks++; if (inst_valid_o !== 1'b1) begin n_fail++;
      $display("FAIL rsth_pre: got %b want 1", inst_valid_o); end
    rst = 1'b1;
    #1;
    n_checks++; if (inst_valid_o !== 1'b0 || fetch_valid_o !== 1'b0) begin n_fail++;
      $display("FAIL rsth_async: got %b/%b want 0/0", inst_valid_o, fetch_valid_o); end
    cyc();
    rst = 1'b0;
    #1;
    n_checks++; if (fetch_valid_o !== 1'b1 || fetch_addr_o !== 32'h8000_0000) begin n_fail++;
      $display("FAIL rsth_first_fetch: got %b/%h want 1/80000000", fetch_valid_o,
               fetch_addr_o); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_straight_line();
    test_backpressure();
    test_branch_in_wait();
    test_br_trap_hold();
    test_redirect_req_stalled();
    test_wrap();
    test_rst_in_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
